// File: rtl/conv_frame_sched.sv
// Paces an upstream pixel stream into a conv_layer: one pixel per HOLD_DATA-cycle slot, with line/frame markers.
// Define CONV_FRAME_SCHED_FLUSH_EN to append FLUSH_LINES zero lines after each frame.
module conv_frame_sched #(
    parameter int DATA_WIDTH  = 8,
    parameter int STRING_LEN  = 224,
    parameter int STRING_NUM  = 224,
    parameter int HOLD_DATA   = 16,
    parameter int FLUSH_LINES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] src_data_i,
    input  logic                  src_valid_i,
    output logic                  src_ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic                  sof_o,
    output logic                  eof_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int COL_W  = $clog2(STRING_LEN);
    localparam int LINE_W = $clog2(STRING_NUM);
    localparam int HOLD_W = (HOLD_DATA > 1) ? $clog2(HOLD_DATA) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(STRING_LEN - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(STRING_NUM - 1);
    // The hold counter counts down to zero, so HOLD_DATA-1 cycles start from HOLD_DATA-2.
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'((HOLD_DATA > 1) ? HOLD_DATA - 2 : 0);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd1;
    localparam logic [2:0] ST_HOLD = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd4;

`ifdef CONV_FRAME_SCHED_FLUSH_EN
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam int FL_W = (FLUSH_LINES > 1) ? $clog2(FLUSH_LINES) : 1;
    localparam logic [FL_W-1:0] FL_LAST = FL_W'((FLUSH_LINES > 0) ? FLUSH_LINES - 1 : 0);
    localparam logic [2:0] EOF_NEXT = (FLUSH_LINES > 0) ? ST_FLUSH : ST_DONE;

    logic [FL_W-1:0] fline_reg;
    logic [FL_W-1:0] fline_next;
`else
    // Without the flush build the frame always ends in DONE whatever FLUSH_LINES says.
    localparam logic [2:0] EOF_NEXT = (FLUSH_LINES >= 0) ? ST_DONE : ST_DONE;
`endif

    logic [2:0]            state_reg;
    logic [2:0]            state_next;
    logic [2:0]            ret_reg;
    logic [2:0]            ret_next;
    logic [COL_W-1:0]      col_reg;
    logic [COL_W-1:0]      col_next;
    logic [LINE_W-1:0]     line_reg;
    logic [LINE_W-1:0]     line_next;
    logic [HOLD_W-1:0]     hold_reg;
    logic [HOLD_W-1:0]     hold_next;

    logic [DATA_WIDTH-1:0] data_reg;
    logic                  valid_reg;
    logic                  sop_reg;
    logic                  eop_reg;
    logic                  sof_reg;
    logic                  eof_reg;

    logic                  emit;
    logic [DATA_WIDTH-1:0] emit_data;
    logic                  emit_sop;
    logic                  emit_eop;
    logic                  emit_sof;
    logic                  emit_eof;
    logic                  slot_go;
    logic [2:0]            slot_target;

    logic                  col_first;
    logic                  col_last;
    logic                  line_first;
    logic                  line_last;

    assign col_first  = (col_reg == '0);
    assign col_last   = (col_reg == COL_LAST);
    assign line_first = (line_reg == '0);
    assign line_last  = (line_reg == LINE_LAST);

    always_comb begin
        state_next  = state_reg;
        ret_next    = ret_reg;
        col_next    = col_reg;
        line_next   = line_reg;
        hold_next   = hold_reg;
`ifdef CONV_FRAME_SCHED_FLUSH_EN
        fline_next  = fline_reg;
`endif
        emit        = 1'b0;
        emit_data   = '0;
        emit_sop    = 1'b0;
        emit_eop    = 1'b0;
        emit_sof    = 1'b0;
        emit_eof    = 1'b0;
        slot_go     = 1'b0;
        slot_target = ST_RUN;

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_RUN;
                    col_next   = '0;
                    line_next  = '0;
`ifdef CONV_FRAME_SCHED_FLUSH_EN
                    fline_next = '0;
`endif
                end
            end
            ST_RUN: begin
                if (src_valid_i) begin
                    emit      = 1'b1;
                    emit_data = src_data_i;
                    emit_sop  = col_first;
                    emit_eop  = col_last;
                    emit_sof  = col_first && line_first;
                    emit_eof  = col_last && line_last;
                    if (col_last) begin
                        col_next  = '0;
                        line_next = line_last ? '0 : line_reg + LINE_W'(1);
                    end else begin
                        col_next  = col_reg + COL_W'(1);
                    end
                    slot_go     = 1'b1;
                    slot_target = (col_last && line_last) ? EOF_NEXT : ST_RUN;
                end
            end
            ST_HOLD: begin
                if (hold_reg == '0) begin
                    state_next = ret_reg;
                end else begin
                    hold_next  = hold_reg - HOLD_W'(1);
                end
            end
`ifdef CONV_FRAME_SCHED_FLUSH_EN
            ST_FLUSH: begin
                // Zero words never wait on the source; pacing comes from HOLD alone.
                emit     = 1'b1;
                emit_sop = col_first;
                emit_eop = col_last;
                if (col_last) begin
                    col_next   = '0;
                    fline_next = (fline_reg == FL_LAST) ? '0 : fline_reg + FL_W'(1);
                end else begin
                    col_next   = col_reg + COL_W'(1);
                end
                slot_go     = 1'b1;
                slot_target = (col_last && (fline_reg == FL_LAST)) ? ST_DONE : ST_FLUSH;
            end
`endif
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (slot_go) begin
            if (HOLD_DATA > 1) begin
                state_next = ST_HOLD;
                hold_next  = HOLD_INIT;
                ret_next   = slot_target;
            end else begin
                state_next = slot_target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            ret_reg   <= ST_IDLE;
            col_reg   <= '0;
            line_reg  <= '0;
            hold_reg  <= '0;
`ifdef CONV_FRAME_SCHED_FLUSH_EN
            fline_reg <= '0;
`endif
            data_reg  <= '0;
            valid_reg <= 1'b0;
            sop_reg   <= 1'b0;
            eop_reg   <= 1'b0;
            sof_reg   <= 1'b0;
            eof_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ret_reg   <= ret_next;
            col_reg   <= col_next;
            line_reg  <= line_next;
            hold_reg  <= hold_next;
`ifdef CONV_FRAME_SCHED_FLUSH_EN
            fline_reg <= fline_next;
`endif
            data_reg  <= emit_data;
            valid_reg <= emit;
            sop_reg   <= emit_sop;
            eop_reg   <= emit_eop;
            sof_reg   <= emit_sof;
            eof_reg   <= emit_eof;
        end
    end

    assign src_ready_o  = (state_reg == ST_RUN);
`ifdef CONV_FRAME_SCHED_FLUSH_EN
    assign busy_o       = (state_reg == ST_RUN) || (state_reg == ST_HOLD) || (state_reg == ST_FLUSH);
`else
    assign busy_o       = (state_reg == ST_RUN) || (state_reg == ST_HOLD);
`endif
    assign done_o       = (state_reg == ST_DONE);
    assign data_o       = data_reg;
    assign data_valid_o = valid_reg;
    assign sop_o        = sop_reg;
    assign eop_o        = eop_reg;
    assign sof_o        = sof_reg;
    assign eof_o        = eof_reg;

endmodule
